jt12_ss_port: RTL

Save-state transfer engine that sits on the opposite end of the auto save-state bus exposed by the shift-register delay lines.
- On save, it snapshots the wide state vector in one cycle and streams it out as DW-bit words over a valid/ready interface.
- On load, it accepts DW-bit words, assembles the full vector, and then writes it back atomically with a single-cycle write strobe.
- One instance serves one delay-line group. It sits between the shift-register banks and the system save-state controller.

---
 rtl/jt12_ss_port.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jt12_ss_port.sv
// Save-state port: snapshots a wide state vector and streams it out as DW-bit words (1-cycle latency), or assembles DW-bit words and commits them with one ss_wr strobe.
// Backpressure: sav_data holds while sav_valid && !sav_ready; ld_ready is high throughout LOAD and low during COMMIT.
module jt12_ss_port #(
   parameter int SSW = 160,
   parameter int DW  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           save_req,
   input  logic           load_req,
   input  logic           abort,
   output logic           busy,
   output logic           done,
   input  logic [SSW-1:0] ss_snap,
   output logic [SSW-1:0] ss_load,
   output logic           ss_wr,
   output logic [DW-1:0]  sav_data,
   output logic           sav_valid,
   input  logic           sav_ready,
   input  logic [DW-1:0]  ld_data,
   input  logic           ld_valid,
   output logic           ld_ready
);

   localparam int NW = (SSW + DW - 1) / DW;
   localparam int CW = (NW > 1) ? $clog2(NW) : 1;
   localparam int SW = NW * DW;
   localparam logic [CW-1:0] LAST = CW'(NW - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SAVE,
      S_LOAD,
      S_COMMIT
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NW-1:0][DW-1:0] shadow_q, shadow_d;
   logic                  done_q, done_d;
   logic [SW-1:0]         shadow_flat;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (save_req) begin
               shadow_d = SW'(ss_snap);
               cnt_d    = '0;
               state_d  = S_SAVE;
            end else if (load_req) begin
               shadow_d = '0;
               cnt_d    = '0;
               state_d  = S_LOAD;
            end
         end
         S_SAVE: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (sav_ready) begin
               if (cnt_q == LAST) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (ld_valid) begin
               // padding bits of the last word land above SSW and are never driven out
               shadow_d[cnt_q] = ld_data;
               if (cnt_q == LAST) begin
                  state_d = S_COMMIT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = !abort;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         done_q   <= done_d;
      end
   end

   assign shadow_flat = shadow_q;
   assign ss_load     = shadow_flat[SSW-1:0];
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign sav_valid   = (state_q == S_SAVE);
   assign sav_data    = sav_valid ? shadow_q[cnt_q] : '0;
   assign ld_ready    = (state_q == S_LOAD);
   // an abort landing in the commit cycle cancels the write itself
   assign ss_wr       = (state_q == S_COMMIT) && !abort;

endmodule
